store_buffer: RTL and testbench

- Small FIFO of pending word stores, sitting directly upstream of the data memory in the MEM stage.
- Accepts stores (address, data, pc) from the pipeline and drains one per cycle into the data memory write port (WE/Address/Data/pc).
- Forwards buffered data to same-cycle loads whose word address matches, so loads never read stale memory.

---
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending word stores ahead of data memory with load forwarding (optional STORE_MERGE_EN)
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  input  logic             dm_ready,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_data,
  output logic [31:0]      dm_pc,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);
  logic [31:0] e_addr [DEPTH];
  logic [31:0] e_data [DEPTH];
  logic [31:0] e_pc   [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head, tail, idx;
  logic push, pop, alloc, merge, can_merge;
  assign empty = count == '0;
  assign full  = count == (PTR_W+1)'(DEPTH);
  assign dm_we   = !empty;
  assign dm_addr = empty ? '0 : e_addr[head];
  assign dm_data = empty ? '0 : e_data[head];
  assign dm_pc   = empty ? '0 : e_pc[head];
  assign pop = dm_we & dm_ready;
`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0] last;
  assign last = tail - PTR_W'(1);
  // A store to the youngest entry's word folds into it, unless that entry is leaving this cycle
  assign can_merge = !empty && ((e_addr[last] >> 2) == (st_addr >> 2)) && !(last == head && pop);
`else
  assign can_merge = 1'b0;
`endif
  assign st_ready = !full | can_merge;
  assign push  = st_valid & st_ready;
  assign alloc = push & !can_merge;
  assign merge = push & can_merge;
  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && ((e_addr[idx] >> 2) == (ld_addr >> 2))) begin
        ld_hit  = 1'b1;
        ld_data = e_data[idx];
      end
    end
  end
  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_pc[i]   <= '0;
      end
    end else begin
      if (alloc) begin
        e_addr[tail] <= st_addr;
        e_data[tail] <= st_data;
        e_pc[tail]   <= st_pc;
        valid[tail]  <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
`ifdef STORE_MERGE_EN
      if (merge) begin
        e_data[last] <= st_data;
        e_pc[last]   <= st_pc;
      end
`endif
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
    end
  end
`ifndef STORE_MERGE_EN
  logic unused_merge;
  assign unused_merge = merge;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr, st_data, st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_addr, dm_data, dm_pc;
  logic [2:0]  count;
  logic        empty, full;
  int errors = 0;
  int checks = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .dm_pc(dm_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = 32'h1000 + a;
    step();
    st_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_addr = 32'hFFF0; dm_ready = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(dm_we), 32'd0);
    chk("rst_hit", 32'(ld_hit), 32'd0);
    chk("rst_daddr", dm_addr, 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_full", 32'(full), 32'd0);

    // single store drains the cycle after it is pushed
    dm_ready = 1'b1;
    store(32'h10, 32'hDEADBEEF);
    chk("single_we", 32'(dm_we), 32'd1);
    chk("single_addr", dm_addr, 32'h10);
    chk("single_data", dm_data, 32'hDEADBEEF);
    chk("single_pc", dm_pc, 32'h1010);
    step();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_data0", dm_data, 32'd0);

    // fill to full, 5th store stalls even when a pop happens
    dm_ready = 1'b0;
    store(32'h0, 32'hA0);
    store(32'h4, 32'hA1);
    store(32'h8, 32'hA2);
    store(32'hC, 32'hA3);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(st_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hBAD;
    step();
    chk("stall_count", 32'(count), 32'd4);
    dm_ready = 1'b1;
    #1;
    chk("drain0", dm_addr, 32'h0);
    step();
    st_valid = 1'b0;
    chk("no_pushthru_count", 32'(count), 32'd3);
    chk("drain1", dm_addr, 32'h4);
    step();
    chk("drain2", dm_addr, 32'h8);
    step();
    chk("drain3", dm_addr, 32'hC);
    chk("drain3_data", dm_data, 32'hA3);
    step();
    chk("drain_empty", 32'(empty), 32'd1);

    // wrap pointers
    dm_ready = 1'b0;
    store(32'h30, 32'hB0);
    store(32'h34, 32'hB1);
    store(32'h38, 32'hB2);
    chk("wrap_count", 32'(count), 32'd3);
    dm_ready = 1'b1;
    #1;
    chk("wrap0", dm_addr, 32'h30);
    step();
    chk("wrap1", dm_addr, 32'h34);
    step();
    chk("wrap2", dm_data, 32'hB2);
    step();
    chk("wrap_empty", 32'(empty), 32'd1);

    // forwarding: youngest match wins, low address bits ignored
    dm_ready = 1'b0;
    store(32'h20, 32'h1);
    store(32'h24, 32'h2);
    store(32'h20, 32'h3);
    ld_addr = 32'h20; #1;
    chk("fwd20_hit", 32'(ld_hit), 32'd1);
    chk("fwd20_data", ld_data, 32'h3);
    ld_addr = 32'h22; #1;
    chk("fwd22_hit", 32'(ld_hit), 32'd1);
    chk("fwd22_data", ld_data, 32'h3);
    ld_addr = 32'h24; #1;
    chk("fwd24_data", ld_data, 32'h2);
    ld_addr = 32'h28; #1;
    chk("fwd28_hit", 32'(ld_hit), 32'd0);
    chk("fwd28_data", ld_data, 32'h0);
    st_valid = 1'b1; st_addr = 32'h28; st_data = 32'h9; #1;
    chk("fwd_samecycle_hit", 32'(ld_hit), 32'd0);
    step();
    st_valid = 1'b0; #1;
    chk("fwd_next_hit", 32'(ld_hit), 32'd1);
    chk("fwd_next_data", ld_data, 32'h9);
    // entry being popped is still forwarded
    ld_addr = 32'h20; dm_ready = 1'b1;
    step();
    step();
    ld_addr = 32'h20; #1;
    chk("fwd_pop_head_hit", 32'(ld_hit), 32'd1);
    chk("fwd_pop_head_data", ld_data, 32'h3);
    step();
    chk("fwd_after_pop_hit", 32'(ld_hit), 32'd0);
    step();
    chk("fwd_empty", 32'(empty), 32'd1);
    ld_addr = 32'hFFF0;

    // simultaneous push and pop
    dm_ready = 1'b0;
    store(32'h50, 32'hC0);
    store(32'h54, 32'hC1);
    dm_ready = 1'b1;
    st_valid = 1'b1; st_addr = 32'h58; st_data = 32'hC2; #1;
    chk("pp_addr0", dm_addr, 32'h50);
    step();
    chk("pp_count0", 32'(count), 32'd2);
    chk("pp_addr1", dm_addr, 32'h54);
    st_addr = 32'h5C; st_data = 32'hC3;
    step();
    chk("pp_count1", 32'(count), 32'd2);
    chk("pp_addr2", dm_addr, 32'h58);
    st_addr = 32'h60; st_data = 32'hC4;
    step();
    st_valid = 1'b0;
    chk("pp_count2", 32'(count), 32'd2);
    chk("pp_addr3", dm_addr, 32'h5C);
    step();
    chk("pp_addr4", dm_addr, 32'h60);
    step();
    chk("pp_empty", 32'(empty), 32'd1);

    // merge into youngest entry
    dm_ready = 1'b0;
    store(32'h40, 32'hA);
    store(32'h40, 32'hB);
`ifdef STORE_MERGE_EN
    chk("merge_count", 32'(count), 32'd1);
    chk("merge_data", dm_data, 32'hB);
`else
    chk("merge_count", 32'(count), 32'd2);
    chk("merge_data", dm_data, 32'hA);
`endif
    dm_ready = 1'b1;
    step(); step();
    chk("merge_empty", 32'(empty), 32'd1);

    // reset mid-drain discards pending stores
    dm_ready = 1'b0;
    store(32'h70, 32'hD0);
    store(32'h74, 32'hD1);
    dm_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_we", 32'(dm_we), 32'd0);
    chk("midrst_addr", dm_addr, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_after_we", 32'(dm_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
